store_buffer: RTL
=================

# store_buffer

Write-back store buffer between the MEM-stage pipeline register and the data memory. It accepts committed stores from the pipeline and retires them to data memory one per cycle whenever the memory port is free. It forwards buffered store data to loads whose address matches a pending entry. Stores leave the critical path; the pipeline stalls only when the buffer is full.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 32, address width; word address, matching data-memory indexing
- DATA_W, 32, data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- st_valid  input  1  pipeline presents a store this cycle
- st_addr  input  ADDR_W  store word address
- st_data  input  DATA_W  store data
- st_ready  output  1  buffer can accept a store (not full)
- ld_valid  input  1  pipeline performs a load this cycle
- ld_addr  input  ADDR_W  load word address
- ld_hit  output  1  load address matches a pending entry
- ld_data  output  DATA_W  data of the youngest matching entry; 0 when no hit
- drain_en  input  1  memory port free this cycle (no load using it)
- mem_write  output  1  write strobe to data memory
- mem_address  output  ADDR_W  head entry address
- mem_write_data  output  DATA_W  head entry data
- empty  output  1  no pending entries; used by fences and halt logic
- count  output  $clog2(DEPTH+1)  number of pending entries

## Operation
- Circular FIFO: head pointer (oldest), tail pointer (next free), occupancy count. Pointers wrap modulo DEPTH.
- Enqueue: when st_valid && st_ready, write {st_addr, st_data} at tail, advance tail, set the entry valid.
- st_ready = (count != DEPTH). A full buffer rejects stores even if a drain occurs in the same cycle; there is no pass-through.
- Drain:
  - mem_write = drain_en && !empty.
  - mem_address and mem_write_data always show the head entry, or 0 when empty.
  - On the edge where mem_write=1, the head entry is retired and head advances.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
- Forwarding:
  - ld_hit = ld_valid && some valid entry has addr == ld_addr.
  - ld_data comes from the youngest such entry, searching from tail-1 backwards to head.
  - An entry draining this cycle is still eligible for forwarding.
  - A store being enqueued this cycle is not visible until the next cycle.
- Duplicate addresses are not coalesced. Each store retires in order, so memory ends with the youngest value.
- Address comparison uses the full ADDR_W width.

## Timing
- Reset values: head=0, tail=0, count=0, all entries invalid. Outputs: st_ready=1, empty=1, mem_write=0, ld_hit=0, ld_data=0, mem_address=0, mem_write_data=0.
- Reset asserted mid-operation discards all pending stores immediately, with no drain.
- ld_hit, ld_data, mem_write, mem_address, mem_write_data, st_ready, empty and count are combinational from the current state and inputs. They are valid in the same cycle.
- Minimum store-to-memory latency: a store enqueued at edge N can be written at edge N+1 if drain_en=1 in that cycle.
- Steady-state throughput: one enqueue and one drain per cycle.
- With drain_en held low, DEPTH stores fill the buffer and st_ready drops in the cycle after the DEPTH-th enqueue.

## Structure
- Shared package store_buffer_pkg holds:
  - default DEPTH, ADDR_W and DATA_W constants
  - typedef sb_entry_t {logic valid; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}
- Sub-module store_buffer_match: takes the entry array, head, tail and ld_addr. It returns hit and youngest-match index using an age-ordered priority search. It is purely combinational and is instantiated once.

## Test plan
- Reset: assert rst mid-stream with 3 entries pending -> empty=1, count=0, mem_write=0 immediately; the buffer accepts a store on the first edge after release.
- Single store: store (addr 5, data 25) with drain_en=0 for 2 cycles, then 1 -> mem_write=1 with address 5 and data 25 for exactly one cycle; then empty=1.
- Fill: drain_en=0, four stores to addresses 0–3 -> count=4, st_ready=0. A fifth store is held. drain_en=1 -> memory is written at addresses 0,1,2,3 in order.
- Forwarding: stores (7, 10) then (7, 11), both pending; load addr 7 -> ld_hit=1, ld_data=11. Load addr 8 -> ld_hit=0, ld_data=0.
- Forward during drain: single entry (9, 15) draining this cycle with a load of addr 9 in the same cycle -> ld_hit=1, ld_data=15. The next cycle gives ld_hit=0.
- Wrap-around and simultaneous events: 10 alternating enqueue/drain cycles with continuous traffic -> count stays constant, pointers wrap, and memory order matches store order.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared defaults and entry layout for the write-back store buffer.
// Other files pull these in with import store_buffer_pkg::*.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load-forwarding search: finds the youngest valid entry whose address equals the load address.
// The search walks from tail-1 back towards head. It is purely combinational.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = SB_DEPTH,
    parameter int unsigned ADDR_W  = SB_ADDR_W,
    parameter type         ENTRY_T = sb_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  ENTRY_T            i_entries [DEPTH],
    input  logic [PTR_W-1:0]  i_head,
    input  logic [PTR_W-1:0]  i_tail,
    input  logic [ADDR_W-1:0] i_ld_addr,
    output logic              o_hit,
    output logic [PTR_W-1:0]  o_idx
);

    logic [PTR_W-1:0] w_idx;
    logic             w_done;

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_idx  = '0;
        w_done = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = i_tail - PTR_W'(1) - PTR_W'(i);
            if (!w_done) begin
                if (i_entries[w_idx].valid && (i_entries[w_idx].addr == i_ld_addr)) begin
                    o_hit  = 1'b1;
                    o_idx  = w_idx;
                    w_done = 1'b1;
                end
                // The head is the oldest slot, so the search stops once it has been examined.
                if (w_idx == i_head) begin
                    w_done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory. It retires one store per free
// memory cycle and forwards the youngest pending store data to matching loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    input  logic              drain_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    // Same layout as sb_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq;
    logic             w_deq;
    logic             w_hit;
    logic [PTR_W-1:0] w_match_idx;

    store_buffer_match #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ENTRY_T (entry_t)
    ) u_match (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_tail    (r_tail),
        .i_ld_addr (ld_addr),
        .o_hit     (w_hit),
        .o_idx     (w_match_idx)
    );

    always_comb begin
        empty          = (r_count == '0);
        count          = r_count;
        st_ready       = (r_count != CNT_W'(DEPTH));
        mem_write      = drain_en && !empty;
        mem_address    = empty ? '0 : r_entries[r_head].addr;
        mem_write_data = empty ? '0 : r_entries[r_head].data;
        ld_hit         = ld_valid && w_hit;
        ld_data        = ld_hit ? r_entries[w_match_idx].data : '0;
    end

    // A full buffer refuses stores even when it drains in the same cycle.
    assign w_enq = st_valid && st_ready;
    assign w_deq = mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_entries[r_tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
